// File: rtl/matrix_transpose_seq.sv
// matrix_transpose_seq
//
// Control sequencer for the serial-load butterfly/transpose datapath. It walks one
// NUM_MG x NUM_MG block through three phases: load the butterfly input buffer
// element by element, fire the butterfly and wait for the transpose core, then drain
// the result onto a valid/ready stream. No data passes through this block. It only
// produces buffer selects, handshakes and the latched mode bit.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   start, cfg_ctrl       begin a block (sampled in IDLE only); mode bit latched at start
//   ctrl                  latched mode bit to the transpose core
//   s_valid, s_ready      upstream element handshake while loading
//   in_sel_i, in_sel_j    butterfly input index (flat = i + j*NUM_MG), i fastest
//   bf_in_val             one-cycle butterfly in_val pulse
//   core_out_val          transpose core result ready
//   out_sel_i, out_sel_j  output row/column select, column fastest
//   m_valid, m_ready      downstream element handshake while draining
//   busy                  state is not IDLE
//   done                  one-cycle pulse after the last element is accepted
//   err_timeout           sticky timeout flag, cleared by the next accepted start

module matrix_transpose_seq #(
    parameter  int unsigned NUM_MG   = 16,
    parameter  int unsigned WAIT_MAX = 1024,
    localparam int unsigned IDXW     = $clog2(NUM_MG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            cfg_ctrl,
    output logic            ctrl,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [IDXW-1:0] in_sel_i,
    output logic [IDXW-1:0] in_sel_j,
    output logic            bf_in_val,
    input  logic            core_out_val,
    output logic [IDXW-1:0] out_sel_i,
    output logic [IDXW-1:0] out_sel_j,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            busy,
    output logic            done,
    output logic            err_timeout
);

    localparam int unsigned     WCW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_MG - 1);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFire,
        StWait,
        StDrain
    } state_e;

    state_e          state;
    logic [IDXW-1:0] ld_i;
    logic [IDXW-1:0] ld_j;
    logic [IDXW-1:0] rd_i;
    logic [IDXW-1:0] rd_j;
    logic [IDXW-1:0] rd_nxt_i;
    logic [IDXW-1:0] rd_nxt_j;
    logic [WCW-1:0]  wait_cnt;
    logic            ld_last;
    logic            rd_last;

    assign ld_last = (ld_i == IDX_LAST) && (ld_j == IDX_LAST);
    assign rd_last = (rd_i == IDX_LAST) && (rd_j == IDX_LAST);

    // Row-major successor of the element on output_e; wraps to (0,0) after the last one,
    // which is also what out_sel shows once the block has drained.
    always_comb begin
        rd_nxt_i = rd_i;
        rd_nxt_j = rd_j + 1'b1;
        if (rd_j == IDX_LAST) begin
            rd_nxt_j = '0;
            rd_nxt_i = (rd_i == IDX_LAST) ? '0 : rd_i + 1'b1;
        end
    end

    // output_e is registered from out_sel, so out_sel names what output_e must hold
    // next cycle: the same element while stalled, the next one once accepted.
    always_comb begin
        out_sel_i = '0;
        out_sel_j = '0;
        if ((state == StDrain) && m_valid) begin
            if (m_ready) begin
                out_sel_i = rd_nxt_i;
                out_sel_j = rd_nxt_j;
            end else begin
                out_sel_i = rd_i;
                out_sel_j = rd_j;
            end
        end
    end

    assign s_ready   = (state == StLoad);
    assign bf_in_val = (state == StFire);
    assign busy      = (state != StIdle);
    assign in_sel_i  = ld_i;
    assign in_sel_j  = ld_j;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            ctrl        <= 1'b0;
            err_timeout <= 1'b0;
            done        <= 1'b0;
            m_valid     <= 1'b0;
            ld_i        <= '0;
            ld_j        <= '0;
            rd_i        <= '0;
            rd_j        <= '0;
            wait_cnt    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        ctrl        <= cfg_ctrl;
                        err_timeout <= 1'b0;
                        ld_i        <= '0;
                        ld_j        <= '0;
                        state       <= StLoad;
                    end
                end
                StLoad: begin
                    // s_ready is high throughout LOAD, so s_valid alone is the handshake.
                    if (s_valid) begin
                        if (ld_last) begin
                            ld_i  <= '0;
                            ld_j  <= '0;
                            state <= StFire;
                        end else if (ld_i == IDX_LAST) begin
                            ld_i <= '0;
                            ld_j <= ld_j + 1'b1;
                        end else begin
                            ld_i <= ld_i + 1'b1;
                        end
                    end
                end
                StFire: begin
                    wait_cnt <= '0;
                    state    <= StWait;
                end
                StWait: begin
                    // core_out_val takes priority over a timeout on the same cycle.
                    if (core_out_val) begin
                        rd_i    <= '0;
                        rd_j    <= '0;
                        m_valid <= 1'b0;
                        state   <= StDrain;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StDrain: begin
                    if (!m_valid) begin
                        // Entry cycle: element 0 is being fetched into output_e.
                        m_valid <= 1'b1;
                    end else if (m_ready) begin
                        if (rd_last) begin
                            m_valid <= 1'b0;
                            done    <= 1'b1;
                            rd_i    <= '0;
                            rd_j    <= '0;
                            state   <= StIdle;
                        end else begin
                            rd_i <= rd_nxt_i;
                            rd_j <= rd_nxt_j;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/matrix_transpose_seq.md
Name: matrix_transpose_seq

Overview:
- Sequencer for the serial-load butterfly/transpose datapath.
- Streams NUM_MG*NUM_MG input elements into the butterfly input buffer through the in-select indices.
- Fires the butterfly valid, waits for the transpose core's out_val, then drains the result through the out-select indices onto a valid/ready output stream.
- Data never passes through this block. It only produces selects, handshakes and the mode bit.

Parameters:
- NUM_MG, 16: matrix side; one block is NUM_MG*NUM_MG elements.
- WAIT_MAX, 1024: maximum cycles in WAIT before a timeout error.
- IDXW, $clog2(NUM_MG): select index width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin one block; sampled only in IDLE
- cfg_ctrl  in  1  transpose mode bit, latched at start
- ctrl  out  1  latched mode to the transpose core
- s_valid  in  1  upstream element on input_e is valid
- s_ready  out  1  sequencer accepts an element this cycle
- in_sel_i  out  IDXW  butterfly input index, low part
- in_sel_j  out  IDXW  butterfly input index, high part (flat = i + j*NUM_MG)
- bf_in_val  out  1  one-cycle pulse to butterfly in_val
- core_out_val  in  1  transpose core out_val
- out_sel_i  out  IDXW  output row select
- out_sel_j  out  IDXW  output column select
- m_valid  out  1  output_e holds a valid element
- m_ready  in  1  downstream accepts output_e
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last element is accepted
- err_timeout  out  1  sticky; cleared at the next accepted start

Behaviour:
- Reset (rst=0, asynchronous) drives every output to 0 and the state to IDLE, from any state. An in-flight block is abandoned and no done is issued.
- States: IDLE, LOAD, FIRE, WAIT, DRAIN.
- IDLE:
  - s_ready=0, m_valid=0.
  - start=1 latches cfg_ctrl into ctrl, clears err_timeout, zeroes the load counter and enters LOAD.
- LOAD:
  - s_ready=1.
  - in_sel_i/j show the current load index: i increments fastest and wraps at NUM_MG-1 with j+1.
  - The datapath writes input_e at the same clock edge on which s_valid&&s_ready is true. The counter advances only on that handshake; no handshake means no advance.
  - The handshake at i=j=NUM_MG-1 enters FIRE.
- FIRE:
  - One cycle. s_ready=0, bf_in_val=1. This gives the last write one cycle to settle.
  - Next state is WAIT; the wait counter is cleared.
- WAIT:
  - core_out_val=1 enters DRAIN.
  - The wait counter increments each cycle. On reaching WAIT_MAX-1 without core_out_val: set err_timeout and return to IDLE; no done.
  - If core_out_val arrives on the same cycle as the limit, core_out_val wins.
- DRAIN (output_e is registered one cycle after the select):
  - rd_idx is the index of the element currently on output_e. Order is row-major: out_sel_j fastest, wrap to out_sel_i+1.
  - out_sel drives the index output_e must hold next cycle:
    - rd_idx while m_valid && !m_ready, so the registered output is re-fetched and stays stable.
    - otherwise rd_idx+1.
  - On the entry cycle, out_sel = 0 and m_valid = 0. From the next cycle m_valid=1, giving throughput of 1 element/cycle under continuous m_ready.
  - m_valid, once high, stays high until accepted. rd_idx advances on m_valid&&m_ready.
  - Acceptance of the last index (NUM_MG-1, NUM_MG-1): m_valid drops next cycle, done pulses for 1 cycle, state returns to IDLE.
  - out_sel after the last element is don't-care and is held at 0.
- start outside IDLE is ignored. start on the done cycle is accepted, since the state is IDLE on that cycle's edge.
- s_ready and m_valid are never high in the same cycle.
- Counters are IDXW bits each, plus a $clog2(WAIT_MAX)-bit wait counter.
- Latency with ideal handshakes: start to done = 1 + N² + 1 + W + 1 + N² + 1 cycles, where W = cycles until core_out_val and N = NUM_MG.

Test Plan:
- NUM_MG=4, start with cfg_ctrl=1, s_valid held high, core_out_val 5 cycles after bf_in_val, m_ready high:
  - in_sel runs (0,0),(1,0)…(3,3) over 16 cycles, then a single bf_in_val pulse.
  - 16 m_valid beats in order (0,0),(0,1)…(3,3); done once; ctrl=1 throughout.
- s_valid toggled 1,0,1,0 during LOAD -> in_sel advances only on the high cycles; 32 cycles are needed to load 16 elements.
- m_ready low for 3 cycles at element 5 -> out_sel holds (1,1), m_valid stays high, element 5 is delivered exactly once, no skip or duplicate.
- WAIT_MAX=8, core_out_val never asserted -> err_timeout=1 and state IDLE 8 cycles after FIRE; no done. A following start clears err_timeout.
- rst asserted mid-DRAIN at element 7 -> all outputs read 0 immediately (asynchronous); after release, busy=0 until a new start; no done.
- start pulsed during LOAD and during WAIT -> no effect on counters, ctrl or state.
